// File: rtl/vga_scaled_frame_buffer.sv
// ---------------------------------------------------------------------------
// vga_scaled_frame_buffer
//
// Frame store that sits between a low-resolution pixel source and the VGA
// timing generator. Source pixels arrive over a valid/ready handshake and are
// written into one bank of the store. During 'bright' they are replayed, each
// source pixel repeated H_SCALE times horizontally and each source line
// repeated V_SCALE times vertically. With DOUBLE_BUF=1 there are two banks.
// A completely written frame is handed to the display side only at a VGA
// frame start (v_sync falling edge).
//
// Ports
//   clk_25      in   pixel clock; all logic on its rising edge
//   reset       in   synchronous, active-high reset
//   h_sync      in   VGA hsync (active low); reserved, not used for timing
//   v_sync      in   VGA vsync (active low); falling edge = frame start
//   bright      in   display enable, high during visible pixels
//   wr_valid    in   source pixel valid
//   wr_ready    out  block can accept a source pixel
//   wr_sof      in   accepted beat is pixel 0 of a frame
//   wr_data     in   source pixel [WIDTH-1:0]
//   pixel_out   out  displayed pixel [WIDTH-1:0], zero when not displaying
//   pixel_valid out  bright delayed by one cycle
//   swap        out  one-cycle pulse when the banks are exchanged
// ---------------------------------------------------------------------------
module vga_scaled_frame_buffer #(
  parameter int WIDTH      = 2,
  parameter int SRC_W      = 160,
  parameter int SRC_H      = 120,
  parameter int H_SCALE    = 4,
  parameter int V_SCALE    = 4,
  parameter int DOUBLE_BUF = 1
) (
  input  logic             clk_25,
  input  logic             reset,
  input  logic             h_sync,
  input  logic             v_sync,
  input  logic             bright,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic             wr_sof,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] pixel_out,
  output logic             pixel_valid,
  output logic             swap
);

  localparam int FRAME  = SRC_W * SRC_H;
  localparam int DEPTH  = (1 + DOUBLE_BUF) * FRAME;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int COL_W  = $clog2(SRC_W + 1);
  localparam int LINE_W = $clog2(SRC_H + 1);
  localparam int HREP_W = (H_SCALE > 1) ? $clog2(H_SCALE) : 1;
  localparam int VREP_W = (V_SCALE > 1) ? $clog2(V_SCALE) : 1;

  localparam logic [AW-1:0]     FRAME_A   = AW'(FRAME);
  localparam logic [AW-1:0]     LAST_OFF  = AW'(FRAME - 1);
  localparam logic [AW-1:0]     SRC_W_A   = AW'(SRC_W);
  localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(SRC_W);
  localparam logic [LINE_W-1:0] LINE_MAX  = LINE_W'(SRC_H);
  localparam logic [HREP_W-1:0] HREP_LAST = HREP_W'(H_SCALE - 1);
  localparam logic [VREP_W-1:0] VREP_LAST = VREP_W'(V_SCALE - 1);

  // hsync is carried for future use; route it to a deliberately unused net
  logic unused_h_sync;
  assign unused_h_sync = h_sync;

  // ---- control state ----
  logic              bright_d_q,   bright_d_d;
  logic              v_sync_d_q,   v_sync_d_d;
  logic              wr_ready_q,   wr_ready_d;
  logic [AW-1:0]     wr_off_q,     wr_off_d;
  logic              frame_full_q, frame_full_d;
  logic              wr_bank_q,    wr_bank_d;
  logic              rd_bank_q,    rd_bank_d;
  logic              swap_q,       swap_d;
  logic [HREP_W-1:0] rd_hrep_q,    rd_hrep_d;
  logic [COL_W-1:0]  rd_col_q,     rd_col_d;
  logic [VREP_W-1:0] rd_vrep_q,    rd_vrep_d;
  logic [LINE_W-1:0] rd_line_q,    rd_line_d;
  logic [AW-1:0]     line_base_q,  line_base_d;
  logic              pixel_valid_q, pixel_valid_d;
  logic              rd_en_q,      rd_en_d;

  // ---- data state (not reset) ----
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  rd_data_q;

  // ---- combinational helpers ----
  logic              v_fall;
  logic              b_fall;
  logic              accept;
  logic              swap_now;
  logic              in_range;
  logic [AW-1:0]     eff_off;
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;
  logic [AW-1:0]     rd_addr;

  always_comb begin
    bright_d_d    = bright;
    v_sync_d_d    = v_sync;
    wr_off_d      = wr_off_q;
    frame_full_d  = frame_full_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    rd_hrep_d     = rd_hrep_q;
    rd_col_d      = rd_col_q;
    rd_vrep_d     = rd_vrep_q;
    rd_line_d     = rd_line_q;
    line_base_d   = line_base_q;
    pixel_valid_d = bright;

    // Edges come from the registered copy against the live input
    v_fall   = v_sync_d_q & ~v_sync;
    b_fall   = bright_d_q & ~bright;

    // ---- write side ----
    accept    = wr_valid & wr_ready_q;
    eff_off   = wr_sof ? '0 : wr_off_q;
    mem_we    = accept & ~reset;
    mem_waddr = (wr_bank_q ? FRAME_A : '0) + eff_off;
    mem_wdata = wr_data;

    if (accept) begin
      if (eff_off == LAST_OFF) begin
        wr_off_d = '0;
        if (DOUBLE_BUF != 0) frame_full_d = 1'b1;
      end else begin
        wr_off_d = eff_off + AW'(1);
      end
    end

    // Only a frame that was already complete before this edge is handed
    // over; one finishing on the edge itself waits for the next frame start.
    swap_now = (DOUBLE_BUF != 0) && v_fall && frame_full_q;
    swap_d   = swap_now;
    if (swap_now) begin
      rd_bank_d    = wr_bank_q;
      wr_bank_d    = rd_bank_q;
      frame_full_d = 1'b0;
      wr_off_d     = '0;
    end

    wr_ready_d = ~frame_full_d;

    // ---- read side ----
    in_range = (rd_col_q < COL_MAX) && (rd_line_q < LINE_MAX);
    rd_en_d  = bright & in_range;
    rd_addr  = (rd_bank_q ? FRAME_A : '0) + line_base_q + AW'(rd_col_q);

    if (!v_sync) begin
      rd_hrep_d   = '0;
      rd_col_d    = '0;
      rd_vrep_d   = '0;
      rd_line_d   = '0;
      line_base_d = '0;
    end else if (bright) begin
      if (rd_hrep_q == HREP_LAST) begin
        rd_hrep_d = '0;
        if (rd_col_q < COL_MAX) rd_col_d = rd_col_q + COL_W'(1);
      end else begin
        rd_hrep_d = rd_hrep_q + HREP_W'(1);
      end
    end else if (b_fall) begin
      rd_hrep_d = '0;
      rd_col_d  = '0;
      if (rd_vrep_q == VREP_LAST) begin
        rd_vrep_d = '0;
        // Line base steps by one source line instead of multiplying
        if (rd_line_q < LINE_MAX) begin
          rd_line_d   = rd_line_q + LINE_W'(1);
          line_base_d = line_base_q + SRC_W_A;
        end
      end else begin
        rd_vrep_d = rd_vrep_q + VREP_W'(1);
      end
    end
  end

  // ---- stage boundary: control registers ----
  always_ff @(posedge clk_25) begin
    if (reset) begin
      bright_d_q    <= 1'b0;
      v_sync_d_q    <= 1'b1;
      wr_ready_q    <= 1'b0;
      wr_off_q      <= '0;
      frame_full_q  <= 1'b0;
      wr_bank_q     <= (DOUBLE_BUF != 0);
      rd_bank_q     <= 1'b0;
      swap_q        <= 1'b0;
      rd_hrep_q     <= '0;
      rd_col_q      <= '0;
      rd_vrep_q     <= '0;
      rd_line_q     <= '0;
      line_base_q   <= '0;
      pixel_valid_q <= 1'b0;
      rd_en_q       <= 1'b0;
    end else begin
      bright_d_q    <= bright_d_d;
      v_sync_d_q    <= v_sync_d_d;
      wr_ready_q    <= wr_ready_d;
      wr_off_q      <= wr_off_d;
      frame_full_q  <= frame_full_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      swap_q        <= swap_d;
      rd_hrep_q     <= rd_hrep_d;
      rd_col_q      <= rd_col_d;
      rd_vrep_q     <= rd_vrep_d;
      rd_line_q     <= rd_line_d;
      line_base_q   <= line_base_d;
      pixel_valid_q <= pixel_valid_d;
      rd_en_q       <= rd_en_d;
    end
  end

  // ---- stage boundary: frame store (read returns pre-write contents) ----
  always_ff @(posedge clk_25) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    if (rd_en_d) rd_data_q <= mem_q[rd_addr];
  end

  // Suppressed reads and blanking both present as zero
  assign pixel_out   = (pixel_valid_q && rd_en_q) ? rd_data_q : '0;
  assign pixel_valid = pixel_valid_q;
  assign wr_ready    = wr_ready_q;
  assign swap        = swap_q;

endmodule
